// File: rtl/y86_pkg.sv
// Shared Y86-64 memory-stage definitions: instruction codes, FSM encoding
// and the default data-RAM size.
package y86_pkg;

    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam int MEM_BYTES_DEF = 1024;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DRAIN  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Bundle between the execute stage, the memory-stage controller and the
// byte-wide data RAM.
//
// Handshake: the client raises start with icode/valE/valA/valP stable; the
// controller accepts on a rising edge where start=1 and busy=0, then holds
// busy=1 from the next cycle through the single-cycle done pulse. start
// seen while busy=1 (including the done cycle) is dropped, not queued.
// valM and dmem_error stay valid from done until the next accepted start.
interface mem_access_ctrl_if;

    logic                  start;
    logic [3:0]            icode;
    logic [63:0]           valE;
    logic [63:0]           valA;
    logic [63:0]           valP;
    logic                  busy;
    logic                  done;
    logic [63:0]           valM;
    logic                  dmem_error;
    logic [63:0]           mem_addr;
    logic [7:0]            mem_wdata;
    logic                  mem_we;
    logic                  mem_re;
    logic [7:0]            mem_rdata;
    y86_pkg::state_t       state;

    // Controller side
    modport slave (
        input  start, icode, valE, valA, valP, mem_rdata,
        output busy, done, valM, dmem_error, mem_addr, mem_wdata, mem_we, mem_re, state
    );

    // Execute stage plus RAM side
    modport master (
        output start, icode, valE, valA, valP, mem_rdata,
        input  busy, done, valM, dmem_error, mem_addr, mem_wdata, mem_we, mem_re, state
    );

endinterface

// File: rtl/mem_req_decode.sv
// Maps an instruction code and its operands onto the memory request:
// base address, 64-bit write data and the access direction.
module mem_req_decode
    import y86_pkg::*;
(
    input  logic [3:0]  icode,
    input  logic [63:0] valE,
    input  logic [63:0] valA,
    input  logic [63:0] valP,
    output logic [63:0] addr,
    output logic [63:0] data,
    output logic        is_read,
    output logic        is_write
);

    // Pure decode: pushes/stores use valE, pops/returns address through valA
    always_comb begin
        addr     = 64'd0;
        data     = 64'd0;
        is_read  = 1'b0;
        is_write = 1'b0;
        case (icode)
            IRMMOVQ: begin addr = valE; data = valA; is_write = 1'b1; end
            ICALL:   begin addr = valE; data = valP; is_write = 1'b1; end
            IPUSHQ:  begin addr = valE; data = valA; is_write = 1'b1; end
            IMRMOVQ: begin addr = valE; is_read = 1'b1; end
            IRET:    begin addr = valA; is_read = 1'b1; end
            IPOPQ:   begin addr = valA; is_read = 1'b1; end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Y86-64 memory-stage controller: serialises one 64-bit little-endian
// access into eight byte accesses on a byte-wide RAM with 1-cycle read
// latency, and reports valM / dmem_error through a start/done handshake.
module mem_access_ctrl
    import y86_pkg::*;
#(
    parameter int MEM_BYTES = MEM_BYTES_DEF,
    parameter int RD_LAT    = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_access_ctrl_if.slave   bus
);

    // Only a single-cycle read latency is implemented
    if (RD_LAT != 1) begin : g_rd_lat_check
        $error("mem_access_ctrl: only RD_LAT=1 is supported");
    end

    // Lowest illegal base address; compared without forming addr+7 so it cannot wrap
    localparam logic [63:0] ADDR_LIMIT = 64'(MEM_BYTES) - 64'd7;

    logic [63:0] req_addr;
    logic [63:0] req_data;
    logic        req_read;
    logic        req_write;
    logic        out_of_range;

    state_t      state;
    logic [2:0]  cnt;
    logic [2:0]  cnt_nxt;
    logic [2:0]  cnt_prev;
    logic [63:0] addr_q;
    logic [63:0] data_q;
    logic        rd_q;
    logic        busy;
    logic        done;
    logic [63:0] valM;
    logic        dmem_error;
    logic [63:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic        mem_re;

    mem_req_decode u_decode (
        .icode    (bus.icode),
        .valE     (bus.valE),
        .valA     (bus.valA),
        .valP     (bus.valP),
        .addr     (req_addr),
        .data     (req_data),
        .is_read  (req_read),
        .is_write (req_write)
    );

    assign out_of_range = (req_addr >= ADDR_LIMIT);
    assign cnt_nxt      = cnt + 3'd1;
    assign cnt_prev     = cnt - 3'd1;

    // Request FSM: accept, byte loop, read drain, done pulse; all outputs registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= 3'd0;
            addr_q     <= 64'd0;
            data_q     <= 64'd0;
            rd_q       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            valM       <= 64'd0;
            dmem_error <= 1'b0;
            mem_addr   <= 64'd0;
            mem_wdata  <= 8'd0;
            mem_we     <= 1'b0;
            mem_re     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        addr_q     <= req_addr;
                        data_q     <= req_data;
                        rd_q       <= req_read;
                        valM       <= 64'd0;
                        dmem_error <= 1'b0;
                        cnt        <= 3'd0;
                        busy       <= 1'b1;
                        if (!(req_read || req_write)) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else if (out_of_range) begin
                            state      <= S_DONE;
                            done       <= 1'b1;
                            dmem_error <= 1'b1;
                        end else begin
                            state     <= S_ACCESS;
                            mem_addr  <= req_addr;
                            mem_wdata <= req_data[7:0];
                            mem_we    <= req_write;
                            mem_re    <= req_read;
                        end
                    end
                end
                S_ACCESS: begin
                    // Byte cnt-1 was read last cycle; its data is on mem_rdata now
                    if (rd_q && (cnt != 3'd0)) begin
                        valM[{cnt_prev, 3'b000} +: 8] <= bus.mem_rdata;
                    end
                    if (cnt == 3'd7) begin
                        mem_we <= 1'b0;
                        mem_re <= 1'b0;
                        if (rd_q) begin
                            state <= S_DRAIN;
                        end else begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end
                    end else begin
                        cnt       <= cnt_nxt;
                        mem_addr  <= addr_q + {61'd0, cnt} + 64'd1;
                        mem_wdata <= data_q[{cnt_nxt, 3'b000} +: 8];
                    end
                end
                S_DRAIN: begin
                    valM[63:56] <= bus.mem_rdata;
                    state       <= S_DONE;
                    done        <= 1'b1;
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy       = busy;
    assign bus.done       = done;
    assign bus.valM       = valM;
    assign bus.dmem_error = dmem_error;
    assign bus.mem_addr   = mem_addr;
    assign bus.mem_wdata  = mem_wdata;
    assign bus.mem_we     = mem_we;
    assign bus.mem_re     = mem_re;
    assign bus.state      = state;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed + light random bench for mem_access_ctrl with a byte RAM model,
// a shadow copy of the expected RAM contents and a result queue.
module tb_mem_access_ctrl;
    import y86_pkg::*;

    localparam int MEM_BYTES = 1024;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mem_access_ctrl_if bus();

    mem_access_ctrl #(.MEM_BYTES(MEM_BYTES), .RD_LAT(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- RAM model ----------------
    logic [7:0] ram    [0:MEM_BYTES-1];
    logic [7:0] shadow [0:MEM_BYTES-1];

    always @(posedge clk) begin
        if (bus.mem_we) ram[bus.mem_addr[9:0]] <= bus.mem_wdata;
        if (bus.mem_re) bus.mem_rdata <= ram[bus.mem_addr[9:0]];
    end

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_err = 0;
    logic [63:0] exp_q [$];
    logic        err_q [$];
    int          lat_q [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] shadow_word(input logic [63:0] a);
        logic [63:0] w;
        for (int i = 0; i < 8; i++) w[8*i +: 8] = shadow[int'(a[9:0]) + i];
        return w;
    endfunction

    // ---------------- driver ----------------
    // Issues one request, then watches it cycle by cycle (cycle 1 = first
    // cycle after the accept edge). s1/s2 are cycles in which start is
    // pulsed again; those pulses must be ignored.
    task automatic run_req(input string tag, input logic [3:0] ic,
                           input logic [63:0] ve, input logic [63:0] va, input logic [63:0] vp,
                           input logic exp_wr, input logic exp_rd,
                           input logic [63:0] base, input logic [63:0] wdata,
                           input logic [63:0] exp_m, input logic exp_e, input int exp_lat,
                           input int s1, input int s2);
        int n;
        int we_cnt;
        int re_cnt;
        int both;
        int done_cnt;
        logic [63:0] pm;
        logic        pe;
        int          pl;
        n = 0; we_cnt = 0; re_cnt = 0; both = 0; done_cnt = 0;
        exp_q.push_back(exp_m);
        err_q.push_back(exp_e);
        lat_q.push_back(exp_lat);
        if (exp_wr) begin
            for (int i = 0; i < 8; i++) shadow[int'(base[9:0]) + i] = wdata[8*i +: 8];
        end
        @(negedge clk);
        bus.icode = ic; bus.valE = ve; bus.valA = va; bus.valP = vp;
        bus.start = 1'b1;
        while (done_cnt == 0 && n < 40) begin
            @(negedge clk);
            n++;
            bus.start = (n == s1 || n == s2);
            if (bus.mem_we && bus.mem_re) both++;
            if (bus.mem_we) begin
                chk({tag, "_waddr"}, bus.mem_addr, base + 64'(we_cnt));
                chk({tag, "_wdata"}, {56'd0, bus.mem_wdata}, {56'd0, wdata[8*we_cnt +: 8]});
                we_cnt++;
            end
            if (bus.mem_re) begin
                chk({tag, "_raddr"}, bus.mem_addr, base + 64'(re_cnt));
                re_cnt++;
            end
            if (bus.done) begin
                done_cnt++;
                pm = exp_q.pop_front();
                pe = err_q.pop_front();
                pl = lat_q.pop_front();
                chk({tag, "_valM"}, bus.valM, pm);
                chk({tag, "_err"}, {63'd0, bus.dmem_error}, {63'd0, pe});
                chk({tag, "_lat"}, 64'(n), 64'(pl));
                chk({tag, "_busy_at_done"}, {63'd0, bus.busy}, 64'd1);
            end
        end
        if (done_cnt == 0) begin
            chk({tag, "_done_timeout"}, {63'd0, bus.done}, 64'd1);
            void'(exp_q.pop_front());
            void'(err_q.pop_front());
            void'(lat_q.pop_front());
        end
        chk({tag, "_we_count"}, 64'(we_cnt), exp_wr ? 64'd8 : 64'd0);
        chk({tag, "_re_count"}, 64'(re_cnt), exp_rd ? 64'd8 : 64'd0);
        chk({tag, "_we_re_overlap"}, 64'(both), 64'd0);
        @(negedge clk);
        bus.start = 1'b0;
        chk({tag, "_busy_after"}, {63'd0, bus.busy}, 64'd0);
        chk({tag, "_done_after"}, {63'd0, bus.done}, 64'd0);
        chk({tag, "_valM_held"}, bus.valM, pm);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [63:0] a;
        logic [63:0] d;
        logic [63:0] d6;
        int sel;

        rst_n = 1'b0;
        bus.start = 1'b0; bus.icode = 4'h0;
        bus.valE = 64'd0; bus.valA = 64'd0; bus.valP = 64'd0;
        for (int i = 0; i < MEM_BYTES; i++) begin
            ram[i]    = 8'(i * 7 + 3);
            shadow[i] = 8'(i * 7 + 3);
        end
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_busy",  {63'd0, bus.busy}, 64'd0);
        chk("rst_done",  {63'd0, bus.done}, 64'd0);
        chk("rst_we",    {63'd0, bus.mem_we}, 64'd0);
        chk("rst_re",    {63'd0, bus.mem_re}, 64'd0);
        chk("rst_err",   {63'd0, bus.dmem_error}, 64'd0);
        chk("rst_valM",  bus.valM, 64'd0);
        chk("rst_addr",  bus.mem_addr, 64'd0);
        chk("rst_wdata", {56'd0, bus.mem_wdata}, 64'd0);
        chk("rst_state", {62'd0, bus.state}, {62'd0, S_IDLE});
        rst_n = 1'b1;
        @(negedge clk);

        // 1. rmmovq write
        run_req("rmmovq", IRMMOVQ, 64'h100, 64'h1122334455667788, 64'd0, 1'b1, 1'b0,
                64'h100, 64'h1122334455667788, 64'd0, 1'b0, 9, 0, 0);
        // 2. mrmovq reads it back
        run_req("mrmovq", IMRMOVQ, 64'h100, 64'd0, 64'd0, 1'b0, 1'b1,
                64'h100, 64'd0, 64'h1122334455667788, 1'b0, 10, 0, 0);
        // 3. out of range, including a near-2^64 address
        run_req("oor_3f9", IRMMOVQ, 64'h3F9, 64'hDEAD, 64'd0, 1'b0, 1'b0,
                64'h3F9, 64'd0, 64'd0, 1'b1, 1, 0, 0);
        run_req("oor_wrap", IRMMOVQ, 64'hFFFF_FFFF_FFFF_FFFC, 64'hBEEF, 64'd0, 1'b0, 1'b0,
                64'd0, 64'd0, 64'd0, 1'b1, 1, 0, 0);
        run_req("oor_popq", IPOPQ, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 1'b0,
                64'd0, 64'd0, 64'd0, 1'b1, 1, 0, 0);
        // Last legal base address
        run_req("edge_3f8", ICALL, 64'h3F8, 64'd0, 64'hA5A5_0102_0304_5A5A, 1'b1, 1'b0,
                64'h3F8, 64'hA5A5_0102_0304_5A5A, 64'd0, 1'b0, 9, 0, 0);
        run_req("edge_3f8_rd", IMRMOVQ, 64'h3F8, 64'd0, 64'd0, 1'b0, 1'b1,
                64'h3F8, 64'd0, 64'hA5A5_0102_0304_5A5A, 1'b0, 10, 0, 0);
        // 4. ret with extra start pulses in cycles 3 and 10
        run_req("ret_hs", IRET, 64'd0, 64'h200, 64'd0, 1'b0, 1'b1,
                64'h200, 64'd0, shadow_word(64'h200), 1'b0, 10, 3, 10);
        // 5. non-memory icode
        run_req("opq", 4'h6, 64'h123, 64'h456, 64'h789, 1'b0, 1'b0,
                64'd0, 64'd0, 64'd0, 1'b0, 1, 0, 0);

        // 6. reset during pushq byte 3; bytes 0..2 land in RAM
        d6 = 64'hCAFE_F00D_1234_5678;
        for (int i = 0; i < 3; i++) shadow[16'h300 + i] = d6[8*i +: 8];
        @(negedge clk);
        bus.icode = IPUSHQ; bus.valE = 64'h300; bus.valA = d6; bus.valP = 64'd0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        chk("rstmid_we_before", {63'd0, bus.mem_we}, 64'd1);
        chk("rstmid_addr_before", bus.mem_addr, 64'h303);
        #1 rst_n = 1'b0;
        #1;
        chk("rstmid_we",   {63'd0, bus.mem_we}, 64'd0);
        chk("rstmid_re",   {63'd0, bus.mem_re}, 64'd0);
        chk("rstmid_busy", {63'd0, bus.busy}, 64'd0);
        chk("rstmid_done", {63'd0, bus.done}, 64'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rstmid_no_done", {63'd0, bus.done}, 64'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        run_req("after_rst_rd", IMRMOVQ, 64'h300, 64'd0, 64'd0, 1'b0, 1'b1,
                64'h300, 64'd0, shadow_word(64'h300), 1'b0, 10, 0, 0);

        // Random write/read pairs across all memory icodes
        for (int r = 0; r < 4; r++) begin
            a   = 64'($urandom_range(0, MEM_BYTES - 8));
            d   = {$urandom, $urandom};
            sel = $urandom_range(0, 2);
            if (sel == 0)
                run_req("rnd_rmmovq", IRMMOVQ, a, d, 64'd0, 1'b1, 1'b0, a, d, 64'd0, 1'b0, 9, 0, 0);
            else if (sel == 1)
                run_req("rnd_pushq", IPUSHQ, a, d, 64'd0, 1'b1, 1'b0, a, d, 64'd0, 1'b0, 9, 0, 0);
            else
                run_req("rnd_call", ICALL, a, 64'd0, d, 1'b1, 1'b0, a, d, 64'd0, 1'b0, 9, 0, 0);
            if ($urandom_range(0, 1) == 0)
                run_req("rnd_popq", IPOPQ, 64'd0, a, 64'd0, 1'b0, 1'b1,
                        a, 64'd0, shadow_word(a), 1'b0, 10, 0, 0);
            else
                run_req("rnd_mrmovq", IMRMOVQ, a, 64'd0, 64'd0, 1'b0, 1'b1,
                        a, 64'd0, shadow_word(a), 1'b0, 10, 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
